// File: rtl/ip_get_dc_ctrl_pkg.sv
// Shared prediction definitions: widths, block-size codes, controller states
// and the reference/prediction word-count lookups.
package ip_get_dc_ctrl_pkg;

    localparam int unsigned REQ_W  = 13;
    localparam int unsigned DAT_W  = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CNT_W  = 9;

    typedef enum logic [1:0] {
        BLK_4  = 2'd0,
        BLK_8  = 2'd1,
        BLK_16 = 2'd2,
        BLK_32 = 2'd3
    } blk_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CONF  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Job configuration word; only the size field is interpreted here.
    typedef struct packed {
        logic [REQ_W-3:0] mode;
        blk_size_e        size;
    } req_cfg_t;

    // Reference words per job equal the block width.
    function automatic logic [ADDR_W-1:0] get_nref(input blk_size_e size);
        logic [ADDR_W-1:0] n;
        case (size)
            BLK_4:   n = ADDR_W'(4);
            BLK_8:   n = ADDR_W'(8);
            BLK_16:  n = ADDR_W'(16);
            default: n = ADDR_W'(32);
        endcase
        return n;
    endfunction

    // Prediction words per job: W*W samples packed four per word.
    function automatic logic [CNT_W-1:0] get_npred(input blk_size_e size);
        logic [CNT_W-1:0] n;
        case (size)
            BLK_4:   n = CNT_W'(4);
            BLK_8:   n = CNT_W'(16);
            BLK_16:  n = CNT_W'(64);
            default: n = CNT_W'(256);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ip_get_dc_ctrl.sv
// DC prediction job controller: loads reference words into the core memories,
// forwards the job configuration, then streams the core's prediction out.
module ip_get_dc_ctrl
    import ip_get_dc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic [REQ_W-1:0]  req_dat,
    input  logic              req_vld,
    output logic              req_rdy,

    input  logic [DAT_W-1:0]  ref_dat,
    input  logic              ref_vld,
    output logic              ref_rdy,

    output logic [DAT_W-1:0]  wdata,
    output logic [ADDR_W-1:0] wraddress,
    output logic              wren,

    output logic [REQ_W-1:0]  conf_dat,
    output logic              conf_vld,
    input  logic              conf_rdy,

    input  logic [DAT_W-1:0]  core_dat,
    input  logic              core_vld,
    output logic              core_rdy,

    output logic [DAT_W-1:0]  pred_dat,
    output logic              pred_vld,
    input  logic              pred_rdy,
    output logic              pred_last,

    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    req_cfg_t          cfg_q, cfg_d;
    logic [ADDR_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [CNT_W-1:0]  pred_cnt_q, pred_cnt_d;
    logic [ADDR_W-1:0] nref_m1;
    logic [CNT_W-1:0]  npred_m1;
    logic              ref_last;
    logic              pred_end;

    assign nref_m1  = ADDR_W'(get_nref(cfg_q.size) - ADDR_W'(1));
    assign npred_m1 = CNT_W'(get_npred(cfg_q.size) - CNT_W'(1));
    assign ref_last = (ref_cnt_q == nref_m1);
    assign pred_end = (pred_cnt_q == npred_m1);

    // State, counters and latched configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            ref_cnt_q  <= '0;
            pred_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            ref_cnt_q  <= ref_cnt_d;
            pred_cnt_q <= pred_cnt_d;
        end
    end

    // Next state and handshake/data outputs; the core stream is a
    // combinational pass-through while draining.
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        ref_cnt_d  = ref_cnt_q;
        pred_cnt_d = pred_cnt_q;
        req_rdy    = 1'b0;
        ref_rdy    = 1'b0;
        wdata      = '0;
        wraddress  = '0;
        wren       = 1'b0;
        conf_dat   = '0;
        conf_vld   = 1'b0;
        core_rdy   = 1'b0;
        pred_dat   = '0;
        pred_vld   = 1'b0;
        pred_last  = 1'b0;
        busy       = (state_q != ST_IDLE);
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_rdy = 1'b1;
                if (req_vld) begin
                    cfg_d      = req_cfg_t'(req_dat);
                    ref_cnt_d  = '0;
                    pred_cnt_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ref_rdy = 1'b1;
                if (ref_vld) begin
                    wren      = 1'b1;
                    wdata     = ref_dat;
                    wraddress = ref_cnt_q;
                    ref_cnt_d = ADDR_W'(ref_cnt_q + ADDR_W'(1));
                    if (ref_last) begin
                        state_d = ST_CONF;
                    end
                end
            end
            ST_CONF: begin
                conf_vld = 1'b1;
                conf_dat = REQ_W'(cfg_q);
                if (conf_rdy) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pred_dat  = core_dat;
                pred_vld  = core_vld;
                core_rdy  = pred_rdy;
                pred_last = pred_end;
                if (core_vld && pred_rdy) begin
                    pred_cnt_d = CNT_W'(pred_cnt_q + CNT_W'(1));
                    if (pred_end) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset quiesces every output in the same cycle it is asserted.
        if (rst) begin
            req_rdy   = 1'b0;
            ref_rdy   = 1'b0;
            wdata     = '0;
            wraddress = '0;
            wren      = 1'b0;
            conf_dat  = '0;
            conf_vld  = 1'b0;
            core_rdy  = 1'b0;
            pred_dat  = '0;
            pred_vld  = 1'b0;
            pred_last = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
        end
    end

endmodule

// File: doc/ip_get_dc_ctrl.md
IP_GET_DC_CTRL -- requirements
Module: ip_get_dc_ctrl

Interface
REQ-001 SHALL have one clock and one reset: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: req_dat  in  13  job configuration word; req_vld  in  1; req_rdy  out  1.
REQ-004 SHALL have: ref_dat  in  32  reference words, 4 packed 8-bit samples; ref_vld  in  1; ref_rdy  out  1.
REQ-005 SHALL have: wdata  out  32; wraddress  out  6; wren  out  1  write port to the DC-core reference memories.
REQ-006 SHALL have: conf_dat  out  13; conf_vld  out  1; conf_rdy  in  1  configuration to the DC core.
REQ-007 SHALL have: core_dat  in  32; core_vld  in  1; core_rdy  out  1  prediction from the DC core.
REQ-008 SHALL have: pred_dat  out  32; pred_vld  out  1; pred_rdy  in  1; pred_last  out  1  prediction to the consumer.
REQ-009 SHALL have: busy  out  1  high when not IDLE; done  out  1  one-cycle pulse at job end.

Function
REQ-010 SHALL decode the block size from req_dat[1:0]: 0=4, 1=8, 2=16, 3=32 (W).
REQ-011 SHALL use reference word count NREF = W (4/8/16/32) and prediction word count NPRED = W*W/4 (4/16/64/256).
REQ-012 SHALL implement states IDLE, LOAD, CONF, DRAIN, DONE.
REQ-013 IDLE: req_rdy=1; on req_vld, SHALL latch req_dat, clear the counters and enter LOAD.
REQ-014 LOAD: ref_rdy=1; each ref_vld beat SHALL drive wren=1, wdata=ref_dat and wraddress=counter in the same cycle, then increment the counter.
REQ-015 LOAD: the beat with counter = NREF-1 SHALL move to CONF; no other cycle SHALL assert wren.
REQ-016 CONF: SHALL hold conf_vld=1 and conf_dat=latched word until conf_rdy, then enter DRAIN.
REQ-017 DRAIN: SHALL combinationally pass core_dat to pred_dat, core_vld to pred_vld and pred_rdy to core_rdy.
REQ-018 DRAIN: SHALL count accepted beats (core_vld & pred_rdy) with a 9-bit counter.
REQ-019 DRAIN: SHALL assert pred_last on the beat with count = NPRED-1, and enter DONE when that beat is accepted.
REQ-020 DONE: SHALL pulse done=1 for exactly one cycle and return to IDLE.
REQ-021 SHALL hold req_rdy, ref_rdy, conf_vld, core_rdy, pred_vld and wren at 0 outside their stated states.
REQ-022 SHALL NOT accept a new request until DONE completes; job latency from request to done = NREF + conf wait + NPRED beats + 2 cycles minimum.
REQ-023 Backpressure: a stall on ref_vld, conf_rdy or pred_rdy SHALL freeze state and counters without data loss or duplication.
REQ-024 SHALL ignore core_vld beats outside DRAIN (core_rdy=0).

Reset
REQ-025 rst SHALL force IDLE, zero all counters and the latched configuration word, on any cycle including mid-job.
REQ-026 During and after reset, outputs SHALL be: req_rdy=0 while rst high then 1 in IDLE; all other vld/rdy, wren, busy, done, pred_last=0; data outputs 0.

Structure
REQ-027 Size codes, the NREF/NPRED lookup, the state enumeration and widths (13, 32, 6) SHALL live in the shared Kvazaar prediction package.
REQ-028 The block SHALL be a single module with no sub-modules; the NREF/NPRED lookup is a package function.

Verification
REQ-029 4x4 job (req_dat=0x000), 4 ref words 0x01010101..0x04040404 -> wren on 4 cycles at addr 0..3, one conf beat 0x000, 4 pred beats with pred_last on the 4th, single done pulse.
REQ-030 32x32 job (req_dat[1:0]=3) with a random ref_vld gap -> 32 writes at addr 0..31 in order, 256 pred beats, pred_last only on beat 255.
REQ-031 conf_rdy held low 10 cycles in CONF -> conf_vld and conf_dat stable for 10 cycles; no pred beat accepted before conf handshake.
REQ-032 pred_rdy toggling every cycle in an 8x8 job -> exactly 16 transfers, none lost or duplicated; core_rdy mirrors pred_rdy.
REQ-033 rst asserted at LOAD beat 2 of a 16x16 job, then a new 4x4 job -> state IDLE next cycle, wren=0, the new job writes from addr 0, done after 4 pred beats.
REQ-034 Second req_vld held during a running job -> req_rdy=0 until the cycle after done, then accepted.
